// File: rtl/mult_scheduler.sv
// Round-robin shared multiplier: N requesters, LAT-deep unsigned multiplier pipeline,
// DEPTH-entry in-order result FIFO, with the outstanding count capped at DEPTH.
module mult_scheduler #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  localparam int IDW  = $clog2(N),
  localparam int OW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*WIDTH-1:0]   req_A,
  input  logic [N*WIDTH-1:0]   req_B,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_product,
  output logic [IDW-1:0]       rsp_id,
  output logic [OW-1:0]        outstanding
);

  logic [IDW-1:0]       r_ptr;
  logic [OW-1:0]        r_out;
  logic [OW-1:0]        r_cnt;
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [LAT:1]         r_vld_pipe;
  logic [2*WIDTH-1:0]   r_pp  [1:LAT];
  logic [IDW-1:0]       r_pid [1:LAT];
  logic [2*WIDTH-1:0]   r_mem_p  [DEPTH];
  logic [IDW-1:0]       r_mem_id [DEPTH];

  logic                 w_gnt_vld;
  logic [IDW-1:0]       w_gidx;
  logic                 w_full;
  logic                 w_issue;
  logic                 w_pop;
  logic                 w_wr;
  logic [WIDTH-1:0]     w_a, w_b;
  logic [2*WIDTH-1:0]   w_prod;

  // Scan from ptr+N-1 down to ptr so the nearest valid requester above ptr wins.
  always_comb begin
    logic [IDW-1:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gidx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(r_ptr) + k) % N);
      if (req_valid[idx]) begin
        w_gnt_vld = 1'b1;
        w_gidx    = idx;
      end
    end
  end

  // Full uses the registered count only, so a same-cycle pop never opens the gate.
  assign w_full    = (r_out == OW'(DEPTH));
  assign req_ready = (rst_n && w_gnt_vld && !w_full) ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
  assign w_issue   = |(req_valid & req_ready);

  assign w_a    = req_A[w_gidx*WIDTH +: WIDTH];
  assign w_b    = req_B[w_gidx*WIDTH +: WIDTH];
  assign w_prod = (2*WIDTH)'(w_a) * (2*WIDTH)'(w_b);

  assign rsp_valid   = (r_cnt != '0);
  assign w_pop       = rsp_valid & rsp_ready;
  assign w_wr        = r_vld_pipe[LAT];
  assign rsp_product = r_mem_p[r_rptr];
  assign rsp_id      = r_mem_id[r_rptr];
  assign outstanding = r_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_out <= '0;
    end else begin
      if (w_issue)
        r_ptr <= (w_gidx == IDW'(N - 1)) ? '0 : w_gidx + 1'b1;
      r_out <= r_out + OW'(w_issue) - OW'(w_pop);
    end
  end

  // Product is formed at issue and carried with its valid bit and id for LAT stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      for (int s = 1; s <= LAT; s++) begin
        r_pp[s]  <= '0;
        r_pid[s] <= '0;
      end
    end else begin
      r_vld_pipe[1] <= w_issue;
      r_pp[1]       <= w_prod;
      r_pid[1]      <= w_gidx;
      for (int s = 2; s <= LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_pp[s]       <= r_pp[s-1];
        r_pid[s]      <= r_pid[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        r_mem_p[d]  <= '0;
        r_mem_id[d] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem_p[r_wptr]  <= r_pp[LAT];
        r_mem_id[r_wptr] <= r_pid[LAT];
        r_wptr           <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop)
        r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + OW'(w_wr) - OW'(w_pop);
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mult_scheduler;
  localparam int N = 4, W = 16, LAT = 2, DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_A = '0, req_B = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [2*W-1:0]  rsp_product;
  logic [1:0]      rsp_id;
  logic [2:0]      outstanding;

  mult_scheduler #(.N(N), .WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_id(rsp_id), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: every accepted op with its product, id and issue edge.
  typedef struct {logic [31:0] prod; int id; int ed;} op_t;
  op_t q[$];
  int  cyc = 0;
  int  ptr_m = 0;

  function automatic logic [N-1:0] model_ready();
    if (!rst_n || q.size() >= DEPTH) return '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr_m + k) % N;
      if (req_valid[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  function automatic logic model_valid();
    return (q.size() > 0) && (q[0].ed + LAT <= cyc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ptr_m = 0;
    end else begin
      logic [N-1:0] g;
      logic         pop;
      g   = model_ready();
      pop = model_valid() && rsp_ready;
      if (pop) void'(q.pop_front());
      cyc++;
      for (int k = 0; k < N; k++)
        if (g[k]) begin
          q.push_back('{prod: 32'(req_A[k*W +: W]) * 32'(req_B[k*W +: W]), id: k, ed: cyc});
          ptr_m = (k + 1) % N;
        end
    end
  end

  // Observed DUT handshakes, for the directed order checks.
  int acc_log[$], rsp_log[$];
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++)
        if (req_valid[k] && req_ready[k]) begin
          acc_log.push_back(k);
          acc_cnt++;
        end
      if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_product", 64'(rsp_product), 64'(0));
      chk("rst_id", 64'(rsp_id), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_outstanding", 64'(outstanding), 64'(0));
    end else begin
      chk("cmp_rsp_valid", 64'(rsp_valid), 64'(model_valid()));
      if (model_valid()) begin
        chk("cmp_product", 64'(rsp_product), 64'(q[0].prod));
        chk("cmp_id", 64'(rsp_id), 64'(q[0].id));
      end
      chk("cmp_outstanding", 64'(outstanding), 64'(q.size()));
      chk("cmp_req_ready", 64'(req_ready), 64'(model_ready()));
    end
  end

  task automatic wait_rsp(input string nm, input logic [31:0] prod, input int id);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, 64'(rsp_valid), 64'(1));
    chk({nm, "_product"}, 64'(rsp_product), 64'(prod));
    chk({nm, "_id"}, 64'(rsp_id), 64'(id));
  endtask

  task automatic issue_one(input int r, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    req_A[r*W +: W] = a;
    req_B[r*W +: W] = b;
    req_valid = N'(1) << r;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int base, base2;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op from requester 2: visible only after edge k+LAT.
    @(posedge clk); #1;
    req_A[2*W +: W] = 16'd5;
    req_B[2*W +: W] = 16'd3;
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); chk("lat_k0", 64'(rsp_valid), 64'(0));
    @(negedge clk); chk("lat_k1", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    chk("lat_k2_valid", 64'(rsp_valid), 64'(1));
    chk("lat_k2_product", 64'(rsp_product), 64'd15);
    chk("lat_k2_id", 64'(rsp_id), 64'd2);

    issue_one(1, 16'd51733, 16'd13978);
    wait_rsp("big", 32'd723123874, 1);
    issue_one(3, 16'hFFFF, 16'hFFFF);
    wait_rsp("max", 32'hFFFE0001, 3);

    // All requesters held high: round-robin from ptr=0.
    repeat (3) @(posedge clk);
    #1;
    acc_log.delete();
    rsp_log.delete();
    req_A = {16'd40, 16'd30, 16'd20, 16'd10};
    req_B = {16'd7, 16'd6, 16'd5, 16'd4};
    req_valid = 4'hF;
    repeat (6) @(posedge clk);
    #1 req_valid = '0;
    repeat (8) @(posedge clk);
    chk("rr_acc_count", 64'(acc_log.size()), 64'd6);
    chk("rr_rsp_count", 64'(rsp_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_log.size()) chk("rr_acc_order", 64'(acc_log[i]), 64'(exp_order[i]));
      if (i < rsp_log.size()) chk("rr_rsp_order", 64'(rsp_log[i]), 64'(exp_order[i]));
    end

    // Backpressure: requester 0 streams with rsp_ready low.
    #1;
    rsp_ready = 1'b0;
    req_A[0 +: W] = 16'd9;
    req_B[0 +: W] = 16'd11;
    base = acc_cnt;
    req_valid = 4'b0001;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_accepts", 64'(acc_cnt - base), 64'd4);
    chk("bp_ready", 64'(req_ready), 64'd0);
    chk("bp_outstanding", 64'(outstanding), 64'd4);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    base2 = acc_cnt;
    chk("bp_no_accept_on_pop", 64'(acc_cnt - base), 64'd4);
    @(posedge clk); #1;
    chk("bp_accept_after_pop", 64'(acc_cnt - base2), 64'd1);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge clk);

    // Reset with three results buffered.
    #1;
    rsp_ready = 1'b0;
    req_A[1*W +: W] = 16'd12;
    req_B[1*W +: W] = 16'd12;
    req_valid = 4'b0010;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_outstanding", 64'(outstanding), 64'd3);
    chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_now_valid", 64'(rsp_valid), 64'd0);
    chk("rst_now_outstanding", 64'(outstanding), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 64'(rsp_valid), 64'd0);
    end

    issue_one(0, 16'd300, 16'd200);
    wait_rsp("post_rst_op", 32'd60000, 0);
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the operand width.
REQ-003 The block SHALL have parameter LAT, default 2, giving the multiplier pipeline depth in cycles (LAT >= 1).
REQ-004 The block SHALL have parameter DEPTH, default 4, giving the result FIFO depth and the maximum number of outstanding operations.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port req_valid, input, N bits: per-requester request valid.
REQ-008 The block SHALL have port req_ready, output, N bits: per-requester accept.
REQ-009 The block SHALL have port req_A, input, N*WIDTH bits: operand A, with requester i in bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port req_B, input, N*WIDTH bits: operand B, packed the same way as req_A.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a result is available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port rsp_product, output, 2*WIDTH bits: unsigned A*B.
REQ-014 The block SHALL have port rsp_id, output, clog2(N) bits: index of the requester that issued the result.
REQ-015 The block SHALL have port outstanding, output, clog2(DEPTH+1) bits: operations in the pipeline plus entries in the FIFO.

Function
REQ-016 Arbitration SHALL be round-robin with a pointer ptr.
- Grant goes to the first i with req_valid[i]=1, searching from ptr upward modulo N.
REQ-017 On an accepted issue to requester g, ptr SHALL become (g+1) mod N; with no issue, ptr SHALL hold.
REQ-018 req_ready SHALL be combinational and one-hot or zero.
- req_ready[g]=1 only for the granted g.
- All bits are zero when outstanding == DEPTH, using the registered value.
REQ-019 An issue SHALL occur when req_valid[g] & req_ready[g], with at most one issue per cycle.
REQ-020 req_ready SHALL NOT depend on rsp_ready in the same cycle.
- A pop and a full counter in the same cycle still block issue that cycle.
REQ-021 Requesters MAY assert valid before ready, and SHALL hold A and B stable until accepted.
REQ-022 The multiplier SHALL be unsigned, full width, 2*WIDTH-bit result, with no truncation.
REQ-023 The pipeline SHALL carry a valid bit and the requester id alongside the operands.
REQ-024 An operation issued at edge k SHALL be written to the FIFO at edge k+LAT.
- With an empty FIFO, rsp_valid=1 in the cycle after edge k+LAT.
REQ-025 The FIFO SHALL preserve issue order.
- rsp_valid = FIFO non-empty.
- rsp_product and rsp_id show the head entry.
- Pop on rsp_valid & rsp_ready.
REQ-026 rsp_product and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-027 outstanding SHALL change as follows:
- +1 on issue.
- -1 on pop.
- Unchanged on simultaneous issue and pop.
- Never exceeds DEPTH, so the FIFO never overflows.
REQ-028 A simultaneous FIFO write and pop SHALL both take effect, including when the FIFO is empty.
- In that case the write lands and is shown next cycle; no bypass.
REQ-029 FIFO and pipeline pointers SHALL wrap modulo their depth.

Reset
REQ-030 rst_n=0 SHALL asynchronously produce:
- ptr=0, outstanding=0.
- All pipeline valid bits 0 and FIFO empty.
- rsp_valid=0, rsp_product=0, rsp_id=0, req_ready=0.
REQ-031 A reset mid-operation SHALL discard all in-flight and buffered results, with no stale rsp_valid after release.
REQ-032 The first possible issue SHALL occur at the first rising edge with rst_n=1.

Verification
REQ-033 With N=4, LAT=2, DEPTH=4 and rsp_ready=1, the bench SHALL cover:
- Requester 2 only, A=5, B=3, accepted at edge k -> rsp_valid after edge k+2, rsp_product=15, rsp_id=2.
- A=51733, B=13978 -> rsp_product=723123874; A=B=65535 -> rsp_product=0xFFFE0001.
- All four req_valid held high -> accepts in order 0,1,2,3,0,1; responses carry rsp_id in the same order.
REQ-034 Backpressure: requester 0 streams with rsp_ready=0 -> exactly 4 accepts, then req_ready=0 and outstanding=4.
- After one pop, the next accept occurs in the following cycle.
REQ-035 Reset: rst_n pulsed low with 3 outstanding -> rsp_valid=0 and outstanding=0 immediately, and no response appears for 10 cycles after release without new requests.
REQ-036 The bench SHALL model every accepted request against a reference.
- Every accepted request yields exactly one response, in order, with the correct product and id.
- No grant to a requester with req_valid=0.
